// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update arbiter.
package bp_pkg;
  localparam int DEPTH_DEF    = 4;
  localparam int MAX_WAIT_DEF = 8;
  localparam int AGE_W        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FORCE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_entry_t;
endpackage

// File: rtl/bp_upd_fifo.sv
// Circular queue of resolved-branch updates waiting for a predictor table write slot.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  upd_entry_t    push_data,
  input  logic          pop,
  output upd_entry_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  upd_entry_t    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale slots are harmless because count gates their use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/bp_update_arbiter.sv
// Shares the single predictor table port between fetch lookups and queued updates,
// forcing a drain when an update has waited too long or the queue is full.
module bp_update_arbiter
  import bp_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  output logic        lookup_grant,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        upd_ready,
  input  logic        flush,
  output logic        tbl_we,
  output logic [31:0] tbl_pc,
  output logic [31:0] tbl_target,
  output logic        tbl_taken
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state;
  logic [AGE_W-1:0] age;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             force_go;
  upd_entry_t       push_data;
  upd_entry_t       head;

  assign push_data = '{pc: upd_pc, target: upd_target, taken: upd_taken};

  assign upd_ready    = !rst && !flush && !full;
  assign push         = upd_valid && upd_ready;
  assign lookup_grant = !rst && lookup_valid && (state != FORCE);
  assign tbl_we       = !rst && !flush &&
                        ((state == FORCE) || (state == PENDING && !lookup_valid && !empty));
  assign pop          = tbl_we;

  // Starvation fires on the edge where the age counter reaches MAX_WAIT-1.
  assign force_go = (state == PENDING) && !pop &&
                    (((age + 1'b1) == AGE_W'(MAX_WAIT - 1)) || (full && lookup_valid));

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      age   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          age <= '0;
          if (push) state <= PENDING;
        end
        PENDING: begin
          age <= pop ? '0 : age + 1'b1;
          if (force_go)              state <= FORCE;
          else if (count_nxt == '0)  state <= IDLE;
        end
        FORCE: begin
          age   <= '0;
          state <= (count_nxt != '0) ? PENDING : IDLE;
        end
        default: begin
          age   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign tbl_pc     = head.pc;
  assign tbl_target = head.target;
  assign tbl_taken  = head.taken;
endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed and randomized bench for bp_update_arbiter against a queue-based reference model.
module tb_bp_update_arbiter;
  import bp_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lookup_valid = 1'b0;
  logic        lookup_grant;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        upd_ready;
  logic        flush = 1'b0;
  logic        tbl_we;
  logic [31:0] tbl_pc;
  logic [31:0] tbl_target;
  logic        tbl_taken;

  always #5 clk = ~clk;

  bp_update_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_grant (lookup_grant),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .flush        (flush),
    .tbl_we       (tbl_we),
    .tbl_pc       (tbl_pc),
    .tbl_target   (tbl_target),
    .tbl_taken    (tbl_taken)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending updates as a queue, waiting time in cycles, forced-drain flag.
  upd_entry_t  mq[$];
  int          m_age = 0;
  bit          m_forcing = 1'b0;

  logic        o_grant, o_we, o_ready, o_taken;
  logic [31:0] o_pc, o_tgt;
  logic [31:0] wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit fl, input bit lv, input bit uv,
                       input logic [31:0] pc_i, input logic [31:0] tgt_i, input bit tk_i);
    bit         e_grant, e_we, e_ready, pop, push, starve;
    int         sz;
    upd_entry_t e;
    rst = r; flush = fl; lookup_valid = lv; upd_valid = uv;
    upd_pc = pc_i; upd_target = tgt_i; upd_taken = tk_i;
    sz      = mq.size();
    e_ready = !r && !fl && (sz < DEPTH);
    e_we    = !r && !fl && (m_forcing || (sz > 0 && !lv));
    e_grant = !r && lv && !m_forcing;
    @(negedge clk);
    o_grant = lookup_grant; o_we = tbl_we; o_ready = upd_ready;
    o_pc = tbl_pc; o_tgt = tbl_target; o_taken = tbl_taken;
    chk("lookup_grant", o_grant, e_grant);
    chk("tbl_we", o_we, e_we);
    chk("upd_ready", o_ready, e_ready);
    chk("grant_we_exclusive", o_grant & o_we, 0);
    if (sz > 0 && !r) begin
      chk("tbl_pc", o_pc, mq[0].pc);
      chk("tbl_target", o_tgt, mq[0].target);
      chk("tbl_taken", o_taken, mq[0].taken);
    end
    if (o_we) wlog.push_back(o_pc);
    @(posedge clk);
    if (r || fl) begin
      mq.delete();
      m_age = 0;
      m_forcing = 1'b0;
    end else begin
      pop    = e_we;
      push   = uv && e_ready;
      starve = !m_forcing && sz > 0 && !pop &&
               ((m_age + 1 == MAX_WAIT - 1) || (sz == DEPTH && lv));
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = pc_i; e.target = tgt_i; e.taken = tk_i;
        mq.push_back(e);
      end
      if (!m_forcing && sz > 0 && !pop) m_age++;
      else m_age = 0;
      m_forcing = starve;
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Reset
    cycle(1, 0, 1, 1, 32'h1, 32'h2, 1);
    chk("reset_grant", o_grant, 0);
    chk("reset_ready", o_ready, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_ready", o_ready, 1);
    chk("post_reset_we", o_we, 0);

    // Idle drain
    cycle(0, 0, 0, 1, 32'h100, 32'h200, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("drain_we", o_we, 1);
    chk("drain_pc", o_pc, 32'h100);
    chk("drain_target", o_tgt, 32'h200);
    chk("drain_taken", o_taken, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("drain_idle_we", o_we, 0);

    // Starvation
    cycle(0, 0, 1, 1, 32'h300, 32'h400, 0);
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 0);
      chk("starve_grant", o_grant, 1);
      chk("starve_we", o_we, 0);
    end
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("force_we", o_we, 1);
    chk("force_grant", o_grant, 0);
    chk("force_pc", o_pc, 32'h300);
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("after_force_grant", o_grant, 1);
    chk("after_force_we", o_we, 0);

    // Full queue
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 1, 32'h11 + i, 32'h900 + i, i[0]);
    cycle(0, 0, 1, 1, 32'h15, 32'h915, 0);
    chk("full_ready", o_ready, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("full_force_we", o_we, 1);
    chk("full_force_pc", o_pc, 32'h11);
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("full_ready_again", o_ready, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 0, 0, 0);

    // Wrap with alternating lookup pressure
    wlog.delete();
    for (int i = 1; i <= 6; i++) cycle(0, 0, i[0], 1, i, 32'h1000 + i, i[1]);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_count", wlog.size(), 6);
    for (int i = 0; i < 6; i++) if (i < wlog.size()) chk("wrap_order", wlog[i], i + 1);

    // Flush with three queued entries and an offered push
    wlog.delete();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 32'h50 + i, 32'h60 + i, 0);
    cycle(0, 1, 0, 1, 32'hDEAD, 32'hBEEF, 1);
    chk("flush_we", o_we, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("post_flush_we", o_we, 0);
      chk("post_flush_ready", o_ready, 1);
    end
    found = 1'b0;
    foreach (wlog[i]) if (wlog[i] == 32'hDEAD) found = 1'b1;
    chk("flush_dropped", found, 0);

    // Reset during a forced drain
    cycle(0, 0, 1, 1, 32'h700, 32'h800, 1);
    for (int i = 0; i < MAX_WAIT - 1; i++) cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 32'h701, 32'h801, 0);
    chk("rst_force_we", o_we, 0);
    chk("rst_force_grant", o_grant, 0);
    chk("rst_force_ready", o_ready, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("rst_after_ready", o_ready, 1);
    chk("rst_after_we", o_we, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 60,
            $urandom, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_update_arbiter.md
BP_UPDATE_ARBITER -- requirements
Module: bp_update_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning update queue entries (power of two, at least 2).
REQ-002 SHALL have parameter MAX_WAIT, default 8, meaning the maximum number of cycles a queued update may be deferred by lookups.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port lookup_valid, input, 1 bit: fetch requests a predictor read this cycle.
REQ-006 SHALL have port lookup_grant, output, 1 bit: the predictor table port serves the lookup this cycle.
REQ-007 SHALL have port upd_valid, input, 1 bit: execute stage offers a resolved branch.
REQ-008 SHALL have ports upd_pc, input, 32 bits; upd_target, input, 32 bits; upd_taken, input, 1 bit: the resolved branch payload.
REQ-009 SHALL have port upd_ready, output, 1 bit: the queue accepts an update; the transfer occurs when upd_valid and upd_ready are both high.
REQ-010 SHALL have port flush, input, 1 bit: discard all queued updates.
REQ-011 SHALL have port tbl_we, output, 1 bit: write strobe to the predictor table.
REQ-012 SHALL have ports tbl_pc, output, 32 bits; tbl_target, output, 32 bits; tbl_taken, output, 1 bit: the head entry payload, valid when tbl_we is high.

Function
REQ-013 SHALL hold accepted updates in a FIFO (head/tail pointers wrap modulo DEPTH; count range 0..DEPTH); upd_ready = (count < DEPTH) and not flush.
REQ-014 SHALL use FSM states IDLE (count = 0), PENDING (count > 0), FORCE (forced drain of one entry).
REQ-015 SHALL, in IDLE, drive tbl_we = 0 and lookup_grant = lookup_valid.
REQ-016 SHALL, in PENDING, give the lookup priority: lookup_valid = 1 gives lookup_grant = 1 and tbl_we = 0; lookup_valid = 0 gives tbl_we = 1 and pops the head.
REQ-017 SHALL, in FORCE, drive tbl_we = 1 and lookup_grant = 0, pop the head, then leave FORCE after exactly one cycle.
REQ-018 SHALL use a 4-bit-wide age counter (sized for MAX_WAIT) that increments each cycle in PENDING with no pop, and clears on any pop, on flush, and in IDLE.
REQ-019 SHALL transition to FORCE on the next edge when the age counter reaches MAX_WAIT-1 without a pop, or when count = DEPTH and lookup_valid = 1.
REQ-020 SHALL leave FORCE to PENDING when the post-pop count > 0, else to IDLE.
REQ-021 SHALL apply latency: an update accepted at edge N is written no earlier than cycle N+1; there is no write-through bypass.
REQ-022 SHALL, on a simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-023 SHALL, on flush, set count and pointers to 0, set the state to IDLE, and drive tbl_we = 0 in that cycle; a push offered in that cycle is dropped.
REQ-024 SHALL never let lookup_grant and tbl_we both be 1 in the same cycle.
REQ-025 SHALL hold tbl_pc, tbl_target and tbl_taken at the head entry whenever count > 0.

Reset
REQ-026 SHALL, while rst = 1, drive state IDLE, count, pointers and age counter to 0, and tbl_we, lookup_grant and upd_ready to 0.
REQ-027 SHALL, on the first cycle after rst falls, drive upd_ready = 1; rst overrides flush and all pushes and pops, and queue contents are discarded mid-operation.

Structure
REQ-028 SHALL place the state enum, the update entry struct (pc, target, taken) and the DEPTH and MAX_WAIT defaults in the shared package bp_pkg.
REQ-029 SHALL implement the queue as the sub-module bp_upd_fifo (push, pop, full, empty, count, head data), with the FSM and age counter in bp_update_arbiter.

Verification
REQ-030 SHALL check idle drain: push pc=0x100, target=0x200, taken=1, with lookup_valid=0 -> next cycle tbl_we=1 with that payload, then state IDLE.
REQ-031 SHALL check starvation: push 1 entry, lookup_valid held high -> lookup_grant=1 for 7 cycles, then FORCE: tbl_we=1 and lookup_grant=0 for exactly 1 cycle.
REQ-032 SHALL check full: push 4 entries with lookup_valid=1 -> upd_ready=0, FORCE pops one entry, and upd_ready=1 the following cycle.
REQ-033 SHALL check wrap: push 6 entries and pop 6 entries in alternating patterns -> writes in FIFO order 1..6 with pointers wrapped and no loss.
REQ-034 SHALL check flush with count=3 and upd_valid=1 -> next cycle count=0, state IDLE, tbl_we=0, and the offered entry is never written.
REQ-035 SHALL check reset mid-FORCE: assert rst for 1 cycle -> all outputs 0 during reset, upd_ready=1 and tbl_we=0 afterwards.
